// File: rtl/palette_fade_ctrl.sv
// palette_fade_ctrl
// Sequences a screen fade-out, a hold at black, and a fade-in for map
// transitions. It sits between the 16-entry palette LUT and the VGA output.
// Each colour channel is scaled by a brightness level that moves one step
// every STEP_FRAMES frames. The block pulses 'mid' while the screen is fully
// black, so the scene can be swapped without the player seeing it.
//
// Parameters:
//   STEP_FRAMES  frame_tick pulses per brightness step (>=1)
//   HOLD_FRAMES  frame_tick pulses spent at black between the fades (>=1)
//   KEY_INDEX    palette index exempt from fading (PALETTE_FADE_KEY_EN only)
//
// Optional feature macro: PALETTE_FADE_KEY_EN
//   When defined, pixels whose index equals KEY_INDEX skip scaling while
//   blank_n=1, so overlay/HUD colours stay visible during a fade.
//   When undefined, every index is scaled.
//
// Ports:
//   Clk                      clock; all state changes on the rising edge
//   Reset_n                  asynchronous, active-low reset
//   frame_tick               1-cycle pulse per frame (vsync start)
//   start                    1-cycle pulse that begins a fade sequence
//   blank_n                  0 during the blanking interval
//   index                    palette index of the current pixel
//   red_in/green_in/blue_in  palette colour, aligned with index
//   red_out/green_out/blue_out  scaled colour, registered (1-cycle latency)
//   busy                     high while a sequence is in progress
//   mid                      1-cycle pulse on entry to HOLD (screen black)
//   done                     1-cycle pulse when the fade-in completes
module palette_fade_ctrl #(
  parameter int STEP_FRAMES = 2,
  parameter int HOLD_FRAMES = 8,
  parameter int KEY_INDEX   = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       blank_n,
  input  logic [3:0] index,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out,
  output logic       busy,
  output logic       mid,
  output logic       done
);

  localparam int CNT_MAX = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} state_e;

  state_e        state_q;
  logic [4:0]    level_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, mid_q, done_q;
  logic [3:0]    red_q, green_q, blue_q;
  logic [3:0]    red_d, green_d, blue_d;
  logic          key_hit;

  // The full 9-bit product ch*level is formed, and bits [7:4] are kept
  // (floor, no rounding). Level 16 therefore passes the colour through
  // unchanged, and bit 8 can never be set.
  function automatic logic [3:0] scale(input logic [3:0] ch, input logic [4:0] lvl);
    logic [8:0] prod;
    prod = 9'(ch) * 9'(lvl);
    return 4'(prod >> 4);
  endfunction

`ifdef PALETTE_FADE_KEY_EN
  assign key_hit = (index == KEY_INDEX[3:0]);
`else
  logic unused_key;
  assign key_hit    = 1'b0;
  assign unused_key = &{1'b0, index, KEY_INDEX[3:0]};
`endif

  // The sequencer. The step counter counts frame_ticks inside the current
  // state. A level change happens on the edge that samples the counting tick.
  // The final step of each fade changes state in that same update, so the
  // mid/done pulses line up with the level reaching 0 or 16.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      level_q <= 5'd16;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      mid_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mid_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          level_q <= 5'd16;
          if (start) begin
            state_q <= FADE_OUT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (frame_tick) begin
            if (cnt_q == STEP_LAST) begin
              cnt_q <= '0;
              if (level_q <= 5'd1) begin
                level_q <= 5'd0;
                state_q <= HOLD;
                mid_q   <= 1'b1;
              end else begin
                level_q <= level_q - 5'd1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          level_q <= 5'd0;
          if (frame_tick) begin
            if (cnt_q == HOLD_LAST) begin
              cnt_q   <= '0;
              state_q <= FADE_IN;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        FADE_IN: begin
          if (frame_tick) begin
            if (cnt_q == STEP_LAST) begin
              cnt_q <= '0;
              if (level_q >= 5'd15) begin
                level_q <= 5'd16;
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                level_q <= level_q + 5'd1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          level_q <= 5'd16;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Colour path. Blanking forces black. A keyed index passes straight
  // through. Everything else is scaled by the current level.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (blank_n) begin
      if (key_hit) begin
        red_d   = red_in;
        green_d = green_in;
        blue_d  = blue_in;
      end else begin
        red_d   = scale(red_in, level_q);
        green_d = scale(green_in, level_q);
        blue_d  = scale(blue_in, level_q);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red_out   = red_q;
  assign green_out = green_q;
  assign blue_out  = blue_q;
  assign busy      = busy_q;
  assign mid       = mid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Directed testbench for palette_fade_ctrl with the default parameters
// (STEP_FRAMES=2, HOLD_FRAMES=8). A full sequence is 32 fade-out ticks,
// then 8 hold ticks, then 32 fade-in ticks.
module tb_palette_fade_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       blank_n = 1'b1;
  logic [3:0] index = 4'd5;
  logic [3:0] red_in = '0, green_in = '0, blue_in = '0;
  logic [3:0] red_out, green_out, blue_out;
  logic       busy, mid, done;

  int vectors = 0;
  int miscompares = 0;

  // Event bookkeeping, updated on every observed cycle
  int   tickCount = 0;
  int   midCycles = 0;
  int   doneCycles = 0;
  int   midAtTick = 0;
  int   doneAtTick = 0;
  logic busyAtDone = 1'b1;
  logic midDoneTogether = 1'b0;

  always #5 Clk = ~Clk;

  palette_fade_ctrl #(
    .STEP_FRAMES(2),
    .HOLD_FRAMES(8),
    .KEY_INDEX(0)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_tick(frame_tick),
    .start(start),
    .blank_n(blank_n),
    .index(index),
    .red_in(red_in),
    .green_in(green_in),
    .blue_in(blue_in),
    .red_out(red_out),
    .green_out(green_out),
    .blue_out(blue_out),
    .busy(busy),
    .mid(mid),
    .done(done)
  );

  task automatic stepCycle();
    @(posedge Clk);
    #1;
    if (mid) midCycles++;
    if (done) begin
      doneCycles++;
      busyAtDone = busy;
    end
    if (mid && done) midDoneTogether = 1'b1;
  endtask

  task automatic pulseTick();
    frame_tick = 1'b1;
    stepCycle();
    tickCount++;
    if (mid) midAtTick = tickCount;
    if (done) doneAtTick = tickCount;
    frame_tick = 1'b0;
    stepCycle();
  endtask

  task automatic clearEvents();
    tickCount = 0;
    midCycles = 0;
    doneCycles = 0;
    midAtTick = 0;
    doneAtTick = 0;
    busyAtDone = 1'b1;
    midDoneTogether = 1'b0;
  endtask

  task automatic setRgb(input logic [11:0] rgb);
    red_in   = rgb[11:8];
    green_in = rgb[7:4];
    blue_in  = rgb[3:0];
  endtask

  task automatic test_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_rgb: got %h expected 000", {red_out, green_out, blue_out});
    end
    vectors++;
    if ({busy, mid, done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: busy/mid/done got %b expected 000", {busy, mid, done});
    end
    stepCycle();
    stepCycle();
    Reset_n = 1'b1;
  endtask

  task automatic test_idle_identity();
    setRgb(12'h32E);
    blank_n = 1'b1;
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h32E) begin
      miscompares++;
      $display("[TB] FAIL idle_identity: got %h expected 32E", {red_out, green_out, blue_out});
    end
    vectors++;
    if ({busy, mid, done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL idle_flags: busy/mid/done got %b expected 000", {busy, mid, done});
    end
    // frame_tick in IDLE must not start anything
    clearEvents();
    for (int i = 0; i < 3; i++) pulseTick();
    vectors++;
    if ({busy, midCycles != 0, doneCycles != 0} !== 3'b000 ||
        {red_out, green_out, blue_out} !== 12'h32E) begin
      miscompares++;
      $display("[TB] FAIL idle_ticks: busy=%b mids=%0d dones=%0d rgb=%h expected 0/0/0/32E",
               busy, midCycles, doneCycles, {red_out, green_out, blue_out});
    end
  endtask

  task automatic test_fade_out();
    clearEvents();
    setRgb(12'hFFF);
    // The start and a tick arrive together, so this tick is not counted
    start = 1'b1;
    frame_tick = 1'b1;
    stepCycle();
    start = 1'b0;
    frame_tick = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_busy: got %b expected 1", busy);
    end
    for (int i = 0; i < 16; i++) pulseTick();
    // 8 steps taken: level 8
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h777) begin
      miscompares++;
      $display("[TB] FAIL level8_fff: got %h expected 777", {red_out, green_out, blue_out});
    end
    setRgb(12'h8E1);
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h470) begin
      miscompares++;
      $display("[TB] FAIL level8_8e1: got %h expected 470", {red_out, green_out, blue_out});
    end
    setRgb(12'hFFF);
    for (int i = 0; i < 16; i++) pulseTick();
    vectors++;
    if (midAtTick !== 32 || midCycles !== 1) begin
      miscompares++;
      $display("[TB] FAIL mid_pulse: at tick %0d for %0d cycles, expected tick 32 for 1 cycle",
               midAtTick, midCycles);
    end
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h000 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_black: rgb=%h busy=%b expected 000/1",
               {red_out, green_out, blue_out}, busy);
    end
  endtask

  task automatic test_hold_restart();
    // A re-start during HOLD is ignored
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 40; i++) pulseTick();
    vectors++;
    if (doneAtTick !== 72 || doneCycles !== 1) begin
      miscompares++;
      $display("[TB] FAIL done_pulse: at tick %0d for %0d cycles, expected tick 72 for 1 cycle",
               doneAtTick, doneCycles);
    end
    vectors++;
    if (busyAtDone !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_at_done: got %b expected 0", busyAtDone);
    end
    vectors++;
    if (midCycles !== 1 || midDoneTogether !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_done_overlap: mids=%0d together=%b expected 1/0",
               midCycles, midDoneTogether);
    end
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'hFFF || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_bright: rgb=%h busy=%b expected FFF/0",
               {red_out, green_out, blue_out}, busy);
    end
  endtask

  task automatic test_blank();
    setRgb(12'hFFF);
    blank_n = 1'b0;
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL blank: got %h expected 000", {red_out, green_out, blue_out});
    end
    blank_n = 1'b1;
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'hFFF) begin
      miscompares++;
      $display("[TB] FAIL unblank: got %h expected FFF", {red_out, green_out, blue_out});
    end
  endtask

  task automatic test_reset_mid_fade();
    clearEvents();
    setRgb(12'hFFF);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    // 32 out, 8 hold, 4 in: level 2
    for (int i = 0; i < 44; i++) pulseTick();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h111) begin
      miscompares++;
      $display("[TB] FAIL fade_in_level2: got %h expected 111", {red_out, green_out, blue_out});
    end
    Reset_n = 1'b0;
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h000 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_fade: rgb=%h busy=%b expected 000/0",
               {red_out, green_out, blue_out}, busy);
    end
    Reset_n = 1'b1;
    setRgb(12'h32E);
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h32E || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL after_reset_identity: rgb=%h busy=%b expected 32E/0",
               {red_out, green_out, blue_out}, busy);
    end
    for (int i = 0; i < 40; i++) pulseTick();
    vectors++;
    if (doneCycles !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL no_done_after_reset: dones=%0d busy=%b expected 0/0", doneCycles, busy);
    end
  endtask

  task automatic test_key();
    clearEvents();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 32; i++) pulseTick();
    // Now in HOLD at level 0
    index = 4'd0;
    setRgb(12'h32E);
    stepCycle();
    vectors++;
`ifdef PALETTE_FADE_KEY_EN
    if ({red_out, green_out, blue_out} !== 12'h32E) begin
      miscompares++;
      $display("[TB] FAIL key_bypass: got %h expected 32E", {red_out, green_out, blue_out});
    end
`else
    if ({red_out, green_out, blue_out} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL key_disabled: got %h expected 000", {red_out, green_out, blue_out});
    end
`endif
    index = 4'd1;
    stepCycle();
    vectors++;
    if ({red_out, green_out, blue_out} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL nonkey_black: got %h expected 000", {red_out, green_out, blue_out});
    end
  endtask

  initial begin
    test_reset();
    test_idle_identity();
    test_fade_out();
    test_hold_restart();
    test_blank();
    test_reset_mid_fade();
    test_key();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
